serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
Downstream consumer of the registered serial bit produced by the d_ff stage. It frames a bit stream into parallel words: start bit (0), WIDTH data bits LSB-first, stop bit (1). It emits each completed word with a one-cycle valid pulse and flags framing errors. It is the first word-level stage after the bit-sampling flip-flop.

Parameters:
WIDTH, 8, number of data bits per frame (legal range 1..32)

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset, sampled on rising edge of clk
bit_en  input  1  bit strobe; serial_in is consumed only in cycles where bit_en=1
serial_in  input  1  registered serial bit (Q of upstream d_ff)
data_out  output  WIDTH  last successfully received word
data_valid  output  1  one-cycle pulse: data_out updated this cycle
frame_err  output  1  one-cycle pulse: stop bit was 0
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at a rising edge): state=IDLE, bit counter=0, shift register=0, data_out=0, data_valid=0, frame_err=0, busy=0. Reset mid-frame abandons the frame with no valid/err pulse. rst has priority over bit_en.
- Cycles with bit_en=0: no state, counter or shift change. data_valid and frame_err are forced to 0.
- FSM, evaluated only when bit_en=1:
  - IDLE: serial_in=0 -> DATA, counter=0. serial_in=1 -> stay in IDLE (line idle).
  - DATA: shift serial_in into the MSB of the shift register and shift right (LSB-first reception). counter+1. Once WIDTH bits have been taken (counter==WIDTH-1 on this bit) -> STOP.
  - STOP: serial_in=1 -> data_out<=assembled word, data_valid=1 next cycle, -> IDLE. serial_in=0 -> frame_err=1 next cycle, data_out unchanged -> IDLE.
- A 0 sampled in STOP is treated only as an error bit, never as a new start bit. The next start bit is detected only from IDLE.
- Latency: data_valid asserts in the cycle after the clock edge that samples the stop bit (registered output). Back-to-back frames are supported: a start bit is accepted on the bit_en immediately after the stop bit. Minimum frame length is WIDTH+2 strobes.
- data_valid and frame_err are mutually exclusive and never exceed one cycle, even when bit_en is held high continuously.
- busy is 1 in DATA and STOP, 0 in IDLE. It is registered and matches the state.
- The counter width is clog2(WIDTH) bits, minimum 1. The counter never wraps past WIDTH-1.
- No glitch filtering: serial_in is already synchronous to clk.

Decomposition:
- Shared package serial_pkg: state encoding constants ST_IDLE=2'd0, ST_DATA=2'd1, ST_STOP=2'd2; START_BIT=1'b0; STOP_BIT=1'b1.
- One natural sub-module: sipo_shift_reg. It is a WIDTH-bit right-shift register with shift enable and synchronous clear, and it is built from the existing d_ff cells or an equivalent behavioural register. The FSM and counter stay in serial_frame_rx.

Test Plan:
- Reset: hold rst=1 for 2 cycles with serial_in toggling -> data_out=8'h00, data_valid=0, frame_err=0, busy=0.
- Good frame, bit_en=1 every cycle: send 0, bits of 8'hA5 LSB-first (1,0,1,0,0,1,0,1), then 1 -> exactly one data_valid pulse one cycle after the stop bit, data_out=8'hA5, busy low afterwards.
- Framing error: send 0, bits of 8'h3C, then stop=0 -> frame_err pulses once, data_valid stays 0, data_out keeps its previous value 8'hA5.
- Sparse strobe: bit_en=1 every 4th cycle, send frame 8'h81 -> data_out=8'h81. Serial_in changes on non-strobe cycles are ignored.
- Back-to-back: frames 8'h01 then 8'hFE with no idle bits -> two data_valid pulses exactly 10 strobes apart, values 8'h01 then 8'hFE.
- Reset mid-frame: assert rst after 4 data bits, then send a full frame 8'h55 -> no pulse for the aborted frame; data_valid once with data_out=8'h55.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants for the serial framing receiver: FSM state encoding and line levels.
package serial_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_STOP = 2'd2;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out right-shift register: new bits enter at the MSB, so the first bit
// received ends up in the LSB after WIDTH shifts.
module sipo_shift_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             clear_i,
   input  logic             shift_en_i,
   input  logic             data_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   generate
      if (WIDTH == 1) begin : g_single
         assign q_d = data_i;
      end else begin : g_multi
         assign q_d = {data_i, q_q[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (clear_i) begin
         q_q <= '0;
      end else if (shift_en_i) begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Frames a strobed serial bit stream (start 0, WIDTH data bits LSB-first, stop 1) into words,
// pulsing data_valid on a good stop bit and frame_err on a bad one.
module serial_frame_rx
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_en,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             frame_err,
   output logic             busy
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             busy_q;
   logic             shift_en;
   logic [WIDTH-1:0] shift_word;

   sipo_shift_reg #(
      .WIDTH (WIDTH)
   ) u_sipo (
      .clk        (clk),
      .clear_i    (rst),
      .shift_en_i (shift_en),
      .data_i     (serial_in),
      .q_o        (shift_word)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      data_out_d = data_out_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      shift_en   = 1'b0;
      if (bit_en) begin
         case (state_q)
            ST_IDLE: begin
               if (serial_in == START_BIT) begin
                  state_d = ST_DATA;
                  cnt_d   = '0;
               end
            end
            ST_DATA: begin
               shift_en = 1'b1;
               if (cnt_q == LastCnt) begin
                  state_d = ST_STOP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            ST_STOP: begin
               // A 0 here is only an error, never a new start bit.
               state_d = ST_IDLE;
               if (serial_in == STOP_BIT) begin
                  data_out_d = shift_word;
                  valid_d    = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         busy_q     <= (state_d != ST_IDLE);
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = valid_q;
   assign frame_err  = err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: vector table, directed corner sequences and
// randomized traffic against a bit-position reference model.
module tb_serial_frame_rx;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         bit_en = 1'b0;
   logic         serial_in = 1'b1;
   logic [W-1:0] data_out;
   logic         data_valid;
   logic         frame_err;
   logic         busy;

   int checks = 0;
   int failures = 0;

   serial_frame_rx #(
      .WIDTH (W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_en     (bit_en),
      .serial_in  (serial_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Reference model: position in frame (-1 idle, 0..W-1 data, W stop) and bits by index.
   int           m_pos = -1;
   logic [W-1:0] m_word = '0;
   logic [W-1:0] m_data = '0;
   logic         m_valid = 1'b0;
   logic         m_err = 1'b0;

   int           strobe_idx = 0;
   int           pulse_idx[$];
   logic [W-1:0] pulse_data[$];
   int           err_cnt = 0;

   typedef struct {
      logic         r;
      logic         e;
      logic         b;
      logic         v;
      logic         er;
      logic         bz;
      logic [W-1:0] d;
   } vec_t;

   vec_t vec_q[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic e, input logic b);
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (r) begin
         m_pos  = -1;
         m_word = '0;
         m_data = '0;
      end else if (e) begin
         if (m_pos < 0) begin
            if (!b) begin
               m_pos  = 0;
               m_word = '0;
            end
         end else if (m_pos < W) begin
            m_word[m_pos] = b;
            m_pos++;
         end else begin
            if (b) begin
               m_data  = m_word;
               m_valid = 1'b1;
            end else begin
               m_err = 1'b1;
            end
            m_pos = -1;
         end
      end
   endtask

   task automatic apply(input logic r, input logic e, input logic b);
      @(negedge clk);
      rst       = r;
      bit_en    = e;
      serial_in = b;
      @(posedge clk);
      model_step(r, e, b);
      if (e) strobe_idx++;
      #1;
      if (data_valid) begin
         pulse_idx.push_back(strobe_idx);
         pulse_data.push_back(data_out);
      end
      if (frame_err) err_cnt++;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".valid"}, data_valid, m_valid);
      check({tag, ".err"}, frame_err, m_err);
      check({tag, ".busy"}, busy, (m_pos >= 0));
      check({tag, ".data"}, data_out, m_data);
   endtask

   task automatic send_frame(input logic [W-1:0] word, input logic stop, input int gap,
                             input string tag);
      logic [W+1:0] bits;
      bits = {stop, word, 1'b0};
      for (int i = 0; i < W + 2; i++) begin
         for (int g = 0; g < gap; g++) begin
            apply(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            check_model(tag);
         end
         apply(1'b0, 1'b1, bits[i]);
         check_model(tag);
      end
   endtask

   function automatic void add_vec(input logic r, input logic e, input logic b, input logic v,
                                   input logic er, input logic bz, input logic [W-1:0] d);
      vec_t t;
      t.r = r; t.e = e; t.b = b; t.v = v; t.er = er; t.bz = bz; t.d = d;
      vec_q.push_back(t);
   endfunction

   // Expected outputs come straight from the frame rules: busy through data, pulse after stop.
   function automatic void add_frame_vecs(input logic [W-1:0] word, input logic stop,
                                          input logic [W-1:0] prev);
      add_vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, prev);
      for (int i = 0; i < W; i++) add_vec(1'b0, 1'b1, word[i], 1'b0, 1'b0, 1'b1, prev);
      add_vec(1'b0, 1'b1, stop, stop, !stop, 1'b0, stop ? word : prev);
   endfunction

   initial begin
      add_vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      add_vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      add_vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      add_frame_vecs(8'hA5, 1'b1, 8'h00);
      add_vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
      add_frame_vecs(8'h3C, 1'b0, 8'hA5);
      add_vec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5);
      add_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);

      for (int i = 0; i < vec_q.size(); i++) begin
         apply(vec_q[i].r, vec_q[i].e, vec_q[i].b);
         check($sformatf("vec%0d.valid", i), data_valid, vec_q[i].v);
         check($sformatf("vec%0d.err", i), frame_err, vec_q[i].er);
         check($sformatf("vec%0d.busy", i), busy, vec_q[i].bz);
         check($sformatf("vec%0d.data", i), data_out, vec_q[i].d);
      end

      // Sparse strobe: one bit_en every 4th cycle, noise on serial_in in between.
      pulse_idx.delete(); pulse_data.delete(); err_cnt = 0;
      send_frame(8'h81, 1'b1, 3, "sparse");
      repeat (3) begin
         apply(1'b0, 1'b0, 1'b0);
         check_model("sparse_tail");
      end
      check("sparse.pulses", pulse_idx.size(), 1);
      check("sparse.data", data_out, 8'h81);

      // Back-to-back frames with no idle bits between them.
      pulse_idx.delete(); pulse_data.delete(); err_cnt = 0;
      send_frame(8'h01, 1'b1, 0, "b2b");
      send_frame(8'hFE, 1'b1, 0, "b2b");
      apply(1'b0, 1'b1, 1'b1);
      check_model("b2b_tail");
      check("b2b.pulses", pulse_idx.size(), 2);
      if (pulse_idx.size() == 2) begin
         check("b2b.spacing", pulse_idx[1] - pulse_idx[0], 10);
         check("b2b.first", pulse_data[0], 8'h01);
         check("b2b.second", pulse_data[1], 8'hFE);
      end
      check("b2b.errs", err_cnt, 0);

      // Reset after four data bits, then a clean frame.
      pulse_idx.delete(); pulse_data.delete(); err_cnt = 0;
      apply(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 1'(i & 1));
      check("midrst.busy_before", busy, 1'b1);
      apply(1'b1, 1'b1, 1'b0);
      check_model("midrst_rst");
      send_frame(8'h55, 1'b1, 0, "midrst");
      check("midrst.pulses", pulse_idx.size(), 1);
      if (pulse_idx.size() == 1) check("midrst.value", pulse_data[0], 8'h55);
      check("midrst.errs", err_cnt, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         logic r, e, b;
         r = ($urandom_range(0, 99) == 0);
         e = ($urandom_range(0, 3) != 0);
         b = ($urandom_range(0, 2) != 0);
         apply(r, e, b);
         check_model("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
